// File: rtl/csa_tree_sched_if.sv
// Stream, tree and result signals of the CSA tree sequencer.
// slave is the sequencer side; master is the side that feeds operands, models the tree and takes sums.
interface csa_tree_sched_if #(
    parameter int DW   = 26,
    parameter int NOPS = 29,
    parameter int GW   = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic                 in_last;
    logic [NOPS*DW-1:0]   tree_ops;
    logic                 tree_vld;
    logic [DW-1:0]        tree_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_sum;
    logic [GW-1:0]        out_groups;

    modport master (
        output in_valid, in_data, in_last, tree_result, out_ready,
        input  in_ready, tree_ops, tree_vld, out_valid, out_sum, out_groups
    );

    modport slave (
        input  in_valid, in_data, in_last, tree_result, out_ready,
        output in_ready, tree_ops, tree_vld, out_valid, out_sum, out_groups
    );
endinterface

// File: rtl/csa_tree_sched.sv
// Packs an operand stream into NOPS-wide groups for an external pipelined CSA tree and accumulates one sum per job.
// Define CSA_TREE_SCHED_PERF_EN to add the perf_jobs / perf_stall counters.
module csa_tree_sched #(
    parameter int DW       = 26,
    parameter int NOPS     = 29,
    parameter int TREE_LAT = 3,
    parameter int GW       = 8
) (
    input  logic clk,
    input  logic rst_n,
    csa_tree_sched_if.slave bus
`ifdef CSA_TREE_SCHED_PERF_EN
    ,
    output logic [15:0] perf_jobs,
    output logic [15:0] perf_stall
`endif
);
    localparam int CW = $clog2(NOPS + 1);

    typedef enum logic [1:0] {GATHER, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic [DW-1:0]       slot [NOPS];
    logic [CW-1:0]       cnt;
    logic                last_seen;
    logic [DW-1:0]       acc;
    logic [7:0]          outstanding;
    logic [TREE_LAT-1:0] tag;

    logic                capture;
    logic                issuing;
    logic [DW-1:0]       acc_sum;
    logic [7:0]          outstanding_next;
    logic [NOPS*DW-1:0]  issue_ops;

    // Slots past the fill count may hold a previous group's data, so they are masked to zero here.
    always_comb begin
        capture          = tag[TREE_LAT-1];
        issuing          = (state == ISSUE);
        acc_sum          = capture ? acc + bus.tree_result : acc;
        outstanding_next = outstanding + {7'd0, issuing} - {7'd0, capture};
        issue_ops        = '0;
        for (int k = 0; k < NOPS; k++) begin
            if (CW'(k) < cnt) issue_ops[k*DW +: DW] = slot[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= GATHER;
            cnt            <= '0;
            last_seen      <= 1'b0;
            acc            <= '0;
            outstanding    <= '0;
            tag            <= '0;
            for (int k = 0; k < NOPS; k++) slot[k] <= '0;
            bus.in_ready   <= 1'b0;
            bus.tree_ops   <= '0;
            bus.tree_vld   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_sum    <= '0;
            bus.out_groups <= '0;
        end else begin
            // Tree returns are captured in every state so gathering overlaps the tree latency.
            tag          <= TREE_LAT'({tag, bus.tree_vld});
            acc          <= acc_sum;
            outstanding  <= outstanding_next;
            bus.tree_vld <= 1'b0;
            case (state)
                GATHER: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        slot[cnt] <= bus.in_data;
                        cnt       <= cnt + CW'(1);
                        if (cnt == CW'(NOPS - 1) || bus.in_last) begin
                            last_seen    <= bus.in_last;
                            bus.in_ready <= 1'b0;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus.tree_ops   <= issue_ops;
                    bus.tree_vld   <= 1'b1;
                    bus.out_groups <= bus.out_groups + GW'(1);
                    cnt            <= '0;
                    bus.in_ready   <= !last_seen;
                    state          <= last_seen ? DRAIN : GATHER;
                end
                DRAIN: begin
                    if (outstanding_next == '0) begin
                        bus.out_sum   <= acc_sum;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid  <= 1'b0;
                        bus.out_groups <= '0;
                        bus.in_ready   <= 1'b1;
                        acc            <= '0;
                        last_seen      <= 1'b0;
                        state          <= GATHER;
                    end
                end
                default: state <= GATHER;
            endcase
        end
    end

`ifdef CSA_TREE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) perf_jobs <= perf_jobs + 16'd1;
            if (bus.out_valid && !bus.out_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif
endmodule
